jpeg_stream_parser: RTL and testbench
=====================================

JPEG_STREAM_PARSER -- requirements
Module: jpeg_stream_parser

Interface
REQ-001 SHALL have parameter DIM_W, default 12, meaning width of reported frame dimensions (low DIM_W bits of the 16-bit SOF0 fields).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port jvalid, input, 1, byte strobe, one byte per asserted cycle, no backpressure.
REQ-005 SHALL have port jpeg, input, 8, stuffed JPEG byte stream.
REQ-006 SHALL have port dvalid, output, 1, unstuffed entropy-coded byte strobe.
REQ-007 SHALL have port data, output, 8, unstuffed entropy-coded byte.
REQ-008 SHALL have port frame_start, output, 1, one-cycle pulse on SOS completion.
REQ-009 SHALL have port frame_end, output, 1, one-cycle pulse on ECS termination.
REQ-010 SHALL have port width, output, DIM_W, width from last SOF0.
REQ-011 SHALL have port height, output, DIM_W, height from last SOF0.
REQ-012 SHALL have port hdr_valid, output, 1, high once a complete SOF0 is captured since reset.
REQ-013 SHALL have port err, output, 1, sticky protocol-violation flag.

Function
REQ-014 SHALL implement states HUNT, MARK, LEN_H, LEN_L, BODY, ECS, ECS_FF; only cycles with jvalid=1 advance state.
REQ-015 HUNT: 0xFF -> MARK; other bytes discarded.
REQ-016 MARK: 0xFF stays MARK (fill); 0xD8 (SOI) -> HUNT-for-marker, i.e. MARK on next 0xFF; 0xD9 (EOI) -> HUNT; 0xD0-0xD7 ignored -> HUNT; 0x00 outside ECS -> HUNT; any other -> LEN_H.
REQ-017 LEN_H/LEN_L SHALL load a 16-bit segment length; BODY SHALL consume length-2 bytes, then -> HUNT, except SOS -> ECS.
REQ-018 Length 2 SHALL skip BODY directly (zero body bytes); length <2 is a violation -> HUNT.
REQ-019 For SOF0 (0xC0), BODY offsets 1-2 SHALL be height MSB/LSB and offsets 3-4 width MSB/LSB (offset 0 = precision); width/height/hdr_valid SHALL update the cycle after the offset-4 byte.
REQ-020 frame_start SHALL pulse one cycle after the final SOS body byte.
REQ-021 ECS: non-0xFF byte SHALL appear on data with dvalid=1 exactly one cycle after acceptance; 0xFF -> ECS_FF with no output.
REQ-022 ECS_FF: 0x00 -> emit 0xFF one cycle later, return ECS; 0xFF -> stay ECS_FF (fill); 0xD0-0xD7 -> drop, return ECS.
REQ-023 ECS_FF: 0xD9 -> frame_end pulse next cycle, -> HUNT; 0xD8 -> frame_end pulse, -> MARK-expecting state as after SOI (back-to-back frames without EOI SHALL be supported).
REQ-024 ECS_FF: any other marker -> frame_end pulse, then processed as in MARK (LEN_H).
REQ-025 dvalid and frame_end SHALL never be asserted in the same cycle; at most one output byte per input byte.
REQ-026 Gaps in jvalid of any length SHALL not change state or outputs except clearing single-cycle pulses.

Reset
REQ-027 rst SHALL force state HUNT, segment counter 0, dvalid=0, data=0, frame_start=0, frame_end=0, width=0, height=0, hdr_valid=0, err=0 on the next edge.
REQ-028 rst asserted mid-ECS SHALL NOT produce frame_end; a pending ECS_FF byte SHALL be discarded.

Configuration
REQ-029 Macro JPEG_PARSER_CHECK_EN: when defined, err SHALL set on length <2, SOS before any SOF0, non-0xFF byte in HUNT after first SOI, or 0x00 in MARK; err clears only on rst.
REQ-030 Without JPEG_PARSER_CHECK_EN, err SHALL be constant 0 and violations SHALL silently resync to HUNT.

Structure
REQ-031 A shared package jpeg_pkg SHALL hold marker constants (SOI, EOI, SOF0, SOS, RST0-7 range, FILL, STUFF) and the state enumeration.
REQ-032 No sub-module; the FSM, length counter and capture registers are one module.

Verification
REQ-033 Bytes FF D8 FF C0 00 11 08 01 E0 02 80 ... (len 0x11) -> height=0x1E0, width=0x280 (truncated to DIM_W), hdr_valid=1.
REQ-034 After SOS, ECS bytes 12 FF 00 34 -> data 12, FF, 34 on three dvalid cycles, FF emitted one cycle after the 00.
REQ-035 ECS ... 56 FF D9 -> data 56, then frame_end pulse one cycle after D9, no dvalid for FF or D9.
REQ-036 ECS ... FF D8 FF C0 ... second frame -> frame_end pulse, new SOF0 captured, second frame_start pulse.
REQ-037 ECS bytes AB FF FF D3 CD with jvalid gaps of 3 cycles -> data AB, CD only.
REQ-038 With JPEG_PARSER_CHECK_EN, segment FF E0 00 01 -> err=1 held until rst; without macro err stays 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG marker constants and parser state encodings.
package jpeg_pkg;

    // Marker byte values.
    localparam logic [7:0] MK_FILL  = 8'hFF;
    localparam logic [7:0] MK_STUFF = 8'h00;
    localparam logic [7:0] MK_SOI   = 8'hD8;
    localparam logic [7:0] MK_EOI   = 8'hD9;
    localparam logic [7:0] MK_SOF0  = 8'hC0;
    localparam logic [7:0] MK_SOS   = 8'hDA;
    localparam logic [7:0] MK_RST0  = 8'hD0;
    localparam logic [7:0] MK_RST7  = 8'hD7;

    // Parser state encodings.
    localparam logic [2:0] StHunt  = 3'd0;
    localparam logic [2:0] StMark  = 3'd1;
    localparam logic [2:0] StLenH  = 3'd2;
    localparam logic [2:0] StLenL  = 3'd3;
    localparam logic [2:0] StBody  = 3'd4;
    localparam logic [2:0] StEcs   = 3'd5;
    localparam logic [2:0] StEcsFf = 3'd6;

    // True for RST0..RST7 restart markers.
    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b >= MK_RST0) && (b <= MK_RST7);
    endfunction

endpackage

// File: rtl/jpeg_stream_parser.sv
// JPEG byte-stream parser: walks marker segments, captures SOF0 frame
// dimensions and emits the unstuffed entropy-coded segment bytes.
// Optional protocol checking is enabled by defining JPEG_PARSER_CHECK_EN;
// without it err is tied low and violations silently resync to HUNT.
module jpeg_stream_parser
    import jpeg_pkg::*;
#(
    parameter int unsigned DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jvalid,
    input  logic [7:0]       jpeg,
    output logic             dvalid,
    output logic [7:0]       data,
    output logic             frame_start,
    output logic             frame_end,
    output logic [DIM_W-1:0] width,
    output logic [DIM_W-1:0] height,
    output logic             hdr_valid,
    output logic             err
);

    logic [2:0]       state_q, state_d;
    logic [7:0]       marker_q, marker_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       off_q, off_d;
    logic [7:0]       h_hi_q, h_hi_d;
    logic [7:0]       h_lo_q, h_lo_d;
    logic [7:0]       w_hi_q, w_hi_d;
    logic [DIM_W-1:0] width_q, width_d;
    logic [DIM_W-1:0] height_q, height_d;
    logic             hdr_q, hdr_d;
    logic             dvalid_q, dvalid_d;
    logic [7:0]       data_q, data_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;
    logic [15:0]      seglen;

    assign seglen = {len_hi_q, jpeg};

    // Next-state decode; every transition is gated by jvalid, pulses self-clear.
    always_comb begin
        state_d  = state_q;
        marker_d = marker_q;
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        h_hi_d   = h_hi_q;
        h_lo_d   = h_lo_q;
        w_hi_d   = w_hi_q;
        width_d  = width_q;
        height_d = height_q;
        hdr_d    = hdr_q;
        dvalid_d = 1'b0;
        data_d   = data_q;
        fs_d     = 1'b0;
        fe_d     = 1'b0;
        if (jvalid) begin
            case (state_q)
                StHunt: begin
                    if (jpeg == MK_FILL) state_d = StMark;
                end
                StMark: begin
                    if (jpeg == MK_FILL) begin
                        state_d = StMark;
                    end else if (jpeg == MK_SOI || jpeg == MK_EOI || jpeg == MK_STUFF ||
                                 is_rst_marker(jpeg)) begin
                        state_d = StHunt;
                    end else begin
                        marker_d = jpeg;
                        state_d  = StLenH;
                    end
                end
                StLenH: begin
                    len_hi_d = jpeg;
                    state_d  = StLenL;
                end
                StLenL: begin
                    off_d = 3'd0;
                    if (seglen < 16'd2) begin
                        state_d = StHunt;
                    end else if (seglen == 16'd2) begin
                        // Empty body: an SOS header completes right here.
                        if (marker_q == MK_SOS) begin
                            state_d = StEcs;
                            fs_d    = 1'b1;
                        end else begin
                            state_d = StHunt;
                        end
                    end else begin
                        cnt_d   = seglen - 16'd2;
                        state_d = StBody;
                    end
                end
                StBody: begin
                    if (marker_q == MK_SOF0) begin
                        case (off_q)
                            3'd1: h_hi_d = jpeg;
                            3'd2: h_lo_d = jpeg;
                            3'd3: w_hi_d = jpeg;
                            3'd4: begin
                                height_d = DIM_W'({h_hi_q, h_lo_q});
                                width_d  = DIM_W'({w_hi_q, jpeg});
                                hdr_d    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    // Offset saturates; only offsets 0-4 matter.
                    if (off_q != 3'd5) off_d = off_q + 3'd1;
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        if (marker_q == MK_SOS) begin
                            state_d = StEcs;
                            fs_d    = 1'b1;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                StEcs: begin
                    if (jpeg == MK_FILL) begin
                        state_d = StEcsFf;
                    end else begin
                        dvalid_d = 1'b1;
                        data_d   = jpeg;
                    end
                end
                StEcsFf: begin
                    if (jpeg == MK_STUFF) begin
                        dvalid_d = 1'b1;
                        data_d   = MK_FILL;
                        state_d  = StEcs;
                    end else if (jpeg == MK_FILL) begin
                        state_d = StEcsFf;
                    end else if (is_rst_marker(jpeg)) begin
                        state_d = StEcs;
                    end else if (jpeg == MK_EOI || jpeg == MK_SOI) begin
                        // SOI without EOI starts the next frame from marker hunt.
                        fe_d    = 1'b1;
                        state_d = StHunt;
                    end else begin
                        fe_d     = 1'b1;
                        marker_d = jpeg;
                        state_d  = StLenH;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StHunt;
            marker_q <= 8'h00;
            len_hi_q <= 8'h00;
            cnt_q    <= 16'h0000;
            off_q    <= 3'd0;
            h_hi_q   <= 8'h00;
            h_lo_q   <= 8'h00;
            w_hi_q   <= 8'h00;
            width_q  <= '0;
            height_q <= '0;
            hdr_q    <= 1'b0;
            dvalid_q <= 1'b0;
            data_q   <= 8'h00;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            marker_q <= marker_d;
            len_hi_q <= len_hi_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            h_hi_q   <= h_hi_d;
            h_lo_q   <= h_lo_d;
            w_hi_q   <= w_hi_d;
            width_q  <= width_d;
            height_q <= height_d;
            hdr_q    <= hdr_d;
            dvalid_q <= dvalid_d;
            data_q   <= data_d;
            fs_q     <= fs_d;
            fe_q     <= fe_d;
        end
    end

    assign dvalid      = dvalid_q;
    assign data        = data_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign width       = width_q;
    assign height      = height_q;
    assign hdr_valid   = hdr_q;

`ifdef JPEG_PARSER_CHECK_EN
    logic seen_soi_q;
    logic err_q;
    logic viol;

    // Flag protocol violations on the byte being accepted.
    always_comb begin
        viol = 1'b0;
        if (jvalid) begin
            case (state_q)
                StHunt:  viol = (jpeg != MK_FILL) && seen_soi_q;
                StMark:  viol = (jpeg == MK_STUFF) || (jpeg == MK_SOS && !hdr_q);
                StLenL:  viol = (seglen < 16'd2);
                StEcsFf: viol = (jpeg == MK_SOS) && !hdr_q;
                default: viol = 1'b0;
            endcase
        end
    end

    // Sticky error flag and first-SOI tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_soi_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (viol) err_q <= 1'b1;
            if (jvalid && jpeg == MK_SOI && (state_q == StMark || state_q == StEcsFf)) begin
                seen_soi_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_stream_parser.sv
// Directed self-checking bench for jpeg_stream_parser.
module tb_jpeg_stream_parser;

    localparam int unsigned DIM_W = 12;

`ifdef JPEG_PARSER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             jvalid;
    logic [7:0]       jpeg;
    logic             dvalid;
    logic [7:0]       data;
    logic             frame_start;
    logic             frame_end;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic             hdr_valid;
    logic             err;

    int errors = 0;
    int checks = 0;

    jpeg_stream_parser #(.DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .jvalid     (jvalid),
        .jpeg       (jpeg),
        .dvalid     (dvalid),
        .data       (data),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .width      (width),
        .height     (height),
        .hdr_valid  (hdr_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted byte; outputs for it are visible on return.
    task automatic send(input logic [7:0] b);
        jvalid = 1'b1;
        jpeg   = b;
        @(posedge clk);
        #1;
        jvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        jvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] sof_tail [10];
    logic [7:0] sof2_body [9];

    initial begin
        sof_tail  = '{8'h03, 8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
        sof2_body = '{8'h08, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01, 8'h01, 8'h11, 8'h00};
        rst    = 1'b1;
        jvalid = 1'b0;
        jpeg   = 8'h00;
        idle(2);
        rst = 1'b0;

        // Reset values.
        chk("rst_dvalid", 16'(dvalid), 16'h0);
        chk("rst_data", 16'(data), 16'h0);
        chk("rst_fs", 16'(frame_start), 16'h0);
        chk("rst_fe", 16'(frame_end), 16'h0);
        chk("rst_width", 16'(width), 16'h0);
        chk("rst_height", 16'(height), 16'h0);
        chk("rst_hdr", 16'(hdr_valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);

        // SOI + SOF0, len 0x11, height 0x1E0, width 0x280.
        send(8'hFF); send(8'hD8); send(8'hFF); send(8'hC0);
        send(8'h00); send(8'h11);
        send(8'h08); send(8'h01); send(8'hE0); send(8'h02);
        chk("sof_hdr_early", 16'(hdr_valid), 16'h0);
        send(8'h80);
        chk("sof_hdr", 16'(hdr_valid), 16'h1);
        chk("sof_height", 16'(height), 16'h1E0);
        chk("sof_width", 16'(width), 16'h280);
        foreach (sof_tail[i]) send(sof_tail[i]);

        // SOS, len 8 -> 6 body bytes; frame_start after the last.
        send(8'hFF); send(8'hDA); send(8'h00); send(8'h08);
        send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'h3F);
        chk("sos_fs_early", 16'(frame_start), 16'h0);
        send(8'h00);
        chk("sos_fs", 16'(frame_start), 16'h1);
        chk("sos_dv", 16'(dvalid), 16'h0);
        idle(1);
        chk("sos_fs_clear", 16'(frame_start), 16'h0);

        // ECS 12 FF 00 34 56 FF D9.
        send(8'h12);
        chk("ecs_dv12", 16'(dvalid), 16'h1);
        chk("ecs_d12", 16'(data), 16'h12);
        send(8'hFF);
        chk("ecs_dv_ff", 16'(dvalid), 16'h0);
        send(8'h00);
        chk("ecs_dv_stuff", 16'(dvalid), 16'h1);
        chk("ecs_d_stuff", 16'(data), 16'hFF);
        send(8'h34);
        chk("ecs_d34", 16'(data), 16'h34);
        send(8'h56);
        chk("ecs_d56", 16'(data), 16'h56);
        send(8'hFF);
        chk("eoi_dv_ff", 16'(dvalid), 16'h0);
        send(8'hD9);
        chk("eoi_fe", 16'(frame_end), 16'h1);
        chk("eoi_dv", 16'(dvalid), 16'h0);
        idle(1);
        chk("eoi_fe_clear", 16'(frame_end), 16'h0);

        // Empty SOS header, then ECS with 3-cycle gaps, fill and RST.
        send(8'hFF); send(8'hDA); send(8'h00); send(8'h02);
        chk("sos2_fs", 16'(frame_start), 16'h1);
        send(8'hAB);
        chk("gap_dvAB", 16'(dvalid), 16'h1);
        chk("gap_dAB", 16'(data), 16'hAB);
        idle(3);
        chk("gap_idle_dv", 16'(dvalid), 16'h0);
        chk("gap_idle_data", 16'(data), 16'hAB);
        send(8'hFF); idle(3);
        send(8'hFF); idle(3);
        chk("gap_fill_dv", 16'(dvalid), 16'h0);
        send(8'hD3); idle(3);
        chk("gap_rst_dv", 16'(dvalid), 16'h0);
        send(8'hCD);
        chk("gap_dvCD", 16'(dvalid), 16'h1);
        chk("gap_dCD", 16'(data), 16'hCD);

        // Back-to-back frame: FF D8 inside ECS, new SOF0 16x32.
        send(8'hFF); send(8'hD8);
        chk("b2b_fe", 16'(frame_end), 16'h1);
        chk("b2b_dv", 16'(dvalid), 16'h0);
        send(8'hFF); send(8'hC0); send(8'h00); send(8'h0B);
        foreach (sof2_body[i]) send(sof2_body[i]);
        chk("b2b_height", 16'(height), 16'h010);
        chk("b2b_width", 16'(width), 16'h020);
        chk("b2b_hdr", 16'(hdr_valid), 16'h1);
        send(8'hFF); send(8'hDA); send(8'h00); send(8'h02);
        chk("b2b_fs", 16'(frame_start), 16'h1);
        send(8'h77);
        chk("b2b_d77", 16'(data), 16'h77);

        // Non-EOI marker ends the ECS and is parsed as a segment.
        send(8'hFF); send(8'hE0);
        chk("app_fe", 16'(frame_end), 16'h1);
        send(8'h00); send(8'h04); send(8'hAA); send(8'hBB);
        chk("app_dv", 16'(dvalid), 16'h0);
        send(8'hFF); send(8'hDA); send(8'h00); send(8'h02);
        chk("app_resync_fs", 16'(frame_start), 16'h1);
        chk("noerr", 16'(err), 16'h0);

        // Reset with an ECS_FF pending: the FF is discarded.
        send(8'hFF);
        do_reset();
        chk("rst_ecs_fe", 16'(frame_end), 16'h0);
        chk("rst_ecs_hdr", 16'(hdr_valid), 16'h0);
        chk("rst_ecs_width", 16'(width), 16'h0);
        send(8'hD9);
        chk("rst_ecs_d9_fe", 16'(frame_end), 16'h0);
        send(8'h00);
        chk("rst_ecs_00_dv", 16'(dvalid), 16'h0);

        // Length below 2.
        send(8'hFF); send(8'hD8); send(8'hFF); send(8'hE0); send(8'h00); send(8'h01);
        chk("len1_err", 16'(err), 16'(ERR_EXP));
        idle(4);
        chk("len1_err_hold", 16'(err), 16'(ERR_EXP));
        do_reset();
        chk("len1_err_clear", 16'(err), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
